sim_main: RTL and testbench

Simulation harness for the camera image-processing pipeline. It instantiates the design top as `i_top`, whose WISHBONE peripheral port and `i_design_1` clocks are driven hierarchically from the outer bench. It generates a synthetic Bayer raw video stream of X_NUM×Y_NUM pixels into the top's camera-input AXI4-Stream slave, and acts as an always-ready sink for the top's processed output stream. It exposes frame and line counters internally for checking.

---
 rtl/sim_main.sv | 374 +++++++++++++++++++++++++++++++++++++
 tb/tb_sim_main.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_main.sv
// Camera pipeline simulation harness.
// sim_main drives a synthetic Bayer raw stream into the camera top (i_top)
// and counts what comes out the far side. The top exposes a WISHBONE
// peripheral port and a design_1 block whose clocks default to the harness
// clock, so an enclosing bench may force them.

module design_1 (
    input  logic        reset,
    input  logic        clk100,
    input  logic        clk200,
    input  logic        clk250,
    input  logic        throttle,
    input  logic [9:0]  s_tdata,
    input  logic        s_tuser,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [9:0]  m_tdata,
    output logic        m_tuser,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [15:0] alive
);
    logic       stall_phase_r;
    logic [7:0] alive200_r;
    logic [7:0] alive250_r;

    // Accept when the output slot is free; when throttled, refuse every other cycle
    assign s_tready = (m_tready | ~m_tvalid) & ~(throttle & stall_phase_r);
    assign alive    = {alive250_r, alive200_r};

    // Throttle phase toggles each cycle while throttling is enabled
    always_ff @(posedge clk100) begin
        if (reset) begin
            stall_phase_r <= 1'b0;
        end else if (throttle) begin
            stall_phase_r <= ~stall_phase_r;
        end else begin
            stall_phase_r <= 1'b0;
        end
    end

    // Single register slice between camera input and processed output
    always_ff @(posedge clk100) begin
        if (reset) begin
            m_tvalid <= 1'b0;
            m_tdata  <= 10'd0;
            m_tuser  <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (s_tready) begin
            m_tvalid <= s_tvalid;
            m_tdata  <= s_tdata;
            m_tuser  <= s_tuser;
            m_tlast  <= s_tlast;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    // Heartbeat counter in the 200 MHz domain
    always_ff @(posedge clk200) begin
        if (reset) begin
            alive200_r <= 8'd0;
        end else begin
            alive200_r <= alive200_r + 8'd1;
        end
    end

    // Heartbeat counter in the 250 MHz domain
    always_ff @(posedge clk250) begin
        if (reset) begin
            alive250_r <= 8'd0;
        end else begin
            alive250_r <= alive250_r + 8'd1;
        end
    end
endmodule

module camera_top (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] s_axis_tdata,
    input  logic       s_axis_tuser,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [9:0] m_axis_tdata,
    output logic       m_axis_tuser,
    output logic       m_axis_tlast,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready
);
    // Peripheral bus; idle defaults here, an enclosing bench may force them
    logic        wb_peri_rst_i;
    logic        wb_peri_clk_i;
    logic [29:0] wb_peri_adr_i;
    logic [63:0] wb_peri_dat_i;
    logic [63:0] wb_peri_dat_o;
    logic        wb_peri_we_i;
    logic [7:0]  wb_peri_sel_i;
    logic        wb_peri_stb_i;
    logic        wb_peri_ack_o;

    logic        dsn_reset;
    logic        clk100;
    logic        clk200;
    logic        clk250;
    logic [63:0] ctrl_r;
    logic [15:0] alive_s;
    logic        unused_wb_s;

    assign wb_peri_rst_i = 1'b0;
    assign wb_peri_clk_i = clk;
    assign wb_peri_adr_i = 30'd0;
    assign wb_peri_dat_i = 64'd0;
    assign wb_peri_we_i  = 1'b0;
    assign wb_peri_sel_i = 8'd0;
    assign wb_peri_stb_i = 1'b0;
    assign dsn_reset     = reset;
    assign clk100        = clk;
    assign clk200        = clk;
    assign clk250        = clk;
    assign unused_wb_s   = ^{wb_peri_dat_o, wb_peri_ack_o};

    // Register file: byte-writable control word at 0 (bit 0 = throttle), status at 1
    always_ff @(posedge wb_peri_clk_i) begin
        if (reset || wb_peri_rst_i) begin
            ctrl_r        <= 64'd0;
            wb_peri_ack_o <= 1'b0;
            wb_peri_dat_o <= 64'd0;
        end else begin
            wb_peri_ack_o <= wb_peri_stb_i & ~wb_peri_ack_o;
            if (wb_peri_stb_i && wb_peri_we_i && (wb_peri_adr_i == 30'd0)) begin
                for (int i = 0; i < 8; i++) begin
                    if (wb_peri_sel_i[i]) begin
                        ctrl_r[8*i +: 8] <= wb_peri_dat_i[8*i +: 8];
                    end
                end
            end
            if (wb_peri_adr_i == 30'd1) begin
                wb_peri_dat_o <= {48'd0, alive_s};
            end else begin
                wb_peri_dat_o <= ctrl_r;
            end
        end
    end

    design_1 i_design_1 (
        .reset    (dsn_reset),
        .clk100   (clk100),
        .clk200   (clk200),
        .clk250   (clk250),
        .throttle (ctrl_r[0]),
        .s_tdata  (s_axis_tdata),
        .s_tuser  (s_axis_tuser),
        .s_tlast  (s_axis_tlast),
        .s_tvalid (s_axis_tvalid),
        .s_tready (s_axis_tready),
        .m_tdata  (m_axis_tdata),
        .m_tuser  (m_axis_tuser),
        .m_tlast  (m_axis_tlast),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready),
        .alive    (alive_s)
    );
endmodule

module sim_main #(
    parameter int X_NUM   = 1024,
    parameter int Y_NUM   = 64,
    parameter int H_BLANK = 16,
    parameter int V_BLANK = 4
) (
    input  logic clk,
    input  logic reset
);
    typedef enum logic [1:0] {ST_RESET, ST_ACTIVE, ST_HBLANK, ST_VBLANK} state_t;

    localparam int          LINE_CYC = X_NUM + H_BLANK;
    localparam logic [31:0] X_LAST   = 32'(X_NUM - 1);
    localparam logic [31:0] Y_LAST   = 32'(Y_NUM - 1);
    localparam logic [31:0] H_LAST   = 32'(H_BLANK - 1);
    localparam logic [31:0] V_LAST   = 32'(V_BLANK * LINE_CYC - 1);
    localparam logic        ROW_LAST = (X_NUM == 1);

    state_t      state;
    logic [31:0] x;
    logic [31:0] y;
    logic [15:0] frame_cnt;
    logic [31:0] blank_cnt;

    logic [9:0]  src_tdata;
    logic        src_tuser;
    logic        src_tlast;
    logic        src_tvalid;
    logic        src_tready;

    logic [9:0]  dst_tdata;
    logic        dst_tuser;
    logic        dst_tlast;
    logic        dst_tvalid;
    logic        dst_tready;

    logic [31:0] out_line_cnt;
    logic [31:0] out_frame_cnt;
    logic [31:0] out_pix_cnt;

    logic [31:0] nxt_x_s;
    logic [9:0]  nxt_data_s;
    logic        nxt_last_s;
    logic [9:0]  cur_data_s;
    logic        cur_user_s;
    logic        cur_last_s;
    logic [31:0] row_y_s;
    logic [15:0] row_f_s;
    logic [9:0]  row_data_s;
    logic        row_user_s;
    logic        unused_sink_s;

    assign dst_tready    = 1'b1;
    assign unused_sink_s = ^dst_tdata;

    // Test pattern: diagonal ramp that shifts by one every frame
    function automatic logic [9:0] pix_val(input logic [9:0] px, input logic [9:0] py,
                                           input logic [9:0] pf);
        return px + py + pf;
    endfunction

    // Pixel following the current one in the line, and the first pixel of the next row
    always_comb begin
        nxt_x_s    = x + 32'd1;
        nxt_data_s = pix_val(nxt_x_s[9:0], y[9:0], frame_cnt[9:0]);
        nxt_last_s = (nxt_x_s == X_LAST);
        cur_data_s = pix_val(x[9:0], y[9:0], frame_cnt[9:0]);
        cur_user_s = (x == 32'd0) && (y == 32'd0);
        cur_last_s = (x == X_LAST);
        if (y == Y_LAST) begin
            row_y_s = 32'd0;
            row_f_s = frame_cnt + 16'd1;
        end else begin
            row_y_s = y + 32'd1;
            row_f_s = frame_cnt;
        end
        row_data_s = pix_val(10'd0, row_y_s[9:0], row_f_s[9:0]);
        row_user_s = (row_y_s == 32'd0);
    end

    // Source pattern generator FSM with registered stream outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RESET;
            x          <= 32'd0;
            y          <= 32'd0;
            frame_cnt  <= 16'd0;
            blank_cnt  <= 32'd0;
            src_tvalid <= 1'b0;
            src_tdata  <= 10'd0;
            src_tuser  <= 1'b0;
            src_tlast  <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!src_tvalid) begin
                        // only reached right after reset: present the current pixel
                        src_tvalid <= 1'b1;
                        src_tdata  <= cur_data_s;
                        src_tuser  <= cur_user_s;
                        src_tlast  <= cur_last_s;
                    end else if (src_tready) begin
                        if (src_tlast) begin
                            src_tvalid <= 1'b0;
                            src_tuser  <= 1'b0;
                            src_tlast  <= 1'b0;
                            if (H_BLANK != 0) begin
                                state     <= ST_HBLANK;
                                blank_cnt <= 32'd0;
                            end else if ((y == Y_LAST) && (V_BLANK != 0)) begin
                                state     <= ST_VBLANK;
                                blank_cnt <= 32'd0;
                            end else begin
                                x          <= 32'd0;
                                y          <= row_y_s;
                                frame_cnt  <= row_f_s;
                                src_tvalid <= 1'b1;
                                src_tdata  <= row_data_s;
                                src_tuser  <= row_user_s;
                                src_tlast  <= ROW_LAST;
                            end
                        end else begin
                            x         <= nxt_x_s;
                            src_tdata <= nxt_data_s;
                            src_tuser <= 1'b0;
                            src_tlast <= nxt_last_s;
                        end
                    end
                end
                ST_HBLANK: begin
                    if (blank_cnt == H_LAST) begin
                        if ((y == Y_LAST) && (V_BLANK != 0)) begin
                            state     <= ST_VBLANK;
                            blank_cnt <= 32'd0;
                        end else begin
                            state      <= ST_ACTIVE;
                            x          <= 32'd0;
                            y          <= row_y_s;
                            frame_cnt  <= row_f_s;
                            src_tvalid <= 1'b1;
                            src_tdata  <= row_data_s;
                            src_tuser  <= row_user_s;
                            src_tlast  <= ROW_LAST;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + 32'd1;
                    end
                end
                ST_VBLANK: begin
                    if (blank_cnt == V_LAST) begin
                        state      <= ST_ACTIVE;
                        x          <= 32'd0;
                        y          <= row_y_s;
                        frame_cnt  <= row_f_s;
                        src_tvalid <= 1'b1;
                        src_tdata  <= row_data_s;
                        src_tuser  <= row_user_s;
                        src_tlast  <= ROW_LAST;
                    end else begin
                        blank_cnt <= blank_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= ST_RESET;
                end
            endcase
        end
    end

    // Output stream statistics, updated on the edge that completes each beat
    always_ff @(posedge clk) begin
        if (reset) begin
            out_line_cnt  <= 32'd0;
            out_frame_cnt <= 32'd0;
            out_pix_cnt   <= 32'd0;
        end else if (dst_tvalid && dst_tready) begin
            if (dst_tlast) begin
                out_line_cnt <= out_line_cnt + 32'd1;
            end
            if (dst_tuser) begin
                out_frame_cnt <= out_frame_cnt + 32'd1;
                out_pix_cnt   <= 32'd1;
            end else begin
                out_pix_cnt <= out_pix_cnt + 32'd1;
            end
        end
    end

    camera_top i_top (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (src_tdata),
        .s_axis_tuser  (src_tuser),
        .s_axis_tlast  (src_tlast),
        .s_axis_tvalid (src_tvalid),
        .s_axis_tready (src_tready),
        .m_axis_tdata  (dst_tdata),
        .m_axis_tuser  (dst_tuser),
        .m_axis_tlast  (dst_tlast),
        .m_axis_tvalid (dst_tvalid),
        .m_axis_tready (dst_tready)
    );
endmodule

// File: tb/tb_sim_main.sv
// Bench for sim_main: small 8x2 frames, scoreboard on source and sink streams.
module tb_sim_main;
    localparam int XN    = 8;
    localparam int YN    = 2;
    localparam int HB    = 4;
    localparam int VB    = 2;
    localparam int LINE  = XN + HB;
    localparam int FRAME = (YN + VB) * LINE;

    typedef struct packed {
        logic [9:0] d;
        logic       u;
        logic       l;
        logic       s;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    beat_t src_q[$];
    beat_t dst_q[$];

    logic timing_en = 1'b0;
    logic arm_first = 1'b0;
    logic have_sol = 1'b0;
    logic have_user = 1'b0;
    logic cnt_valid = 1'b0;
    logic prev_stall = 1'b0;
    int   first_cyc = -1;
    int   last_sol_cyc = 0;
    int   last_user_cyc = 0;
    int   beat_cnt = 0;
    int   user_beats = 0;
    int   stall_seen = 0;
    logic [9:0] prev_d = 10'd0;
    logic prev_u = 1'b0;
    logic prev_l = 1'b0;

    sim_main #(.X_NUM(XN), .Y_NUM(YN), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frames(input int f0, input int nf);
        beat_t b;
        for (int f = f0; f < f0 + nf; f++) begin
            for (int y = 0; y < YN; y++) begin
                for (int x = 0; x < XN; x++) begin
                    b.d = 10'(x + y + f);
                    b.u = (x == 0) && (y == 0);
                    b.l = (x == XN - 1);
                    b.s = (x == 0);
                    src_q.push_back(b);
                end
            end
        end
    endtask

    task automatic wb_write(input logic [63:0] d);
        force dut.i_top.wb_peri_adr_i = 30'd0;
        force dut.i_top.wb_peri_dat_i = d;
        force dut.i_top.wb_peri_we_i  = 1'b1;
        force dut.i_top.wb_peri_sel_i = 8'hff;
        force dut.i_top.wb_peri_stb_i = 1'b1;
        @(posedge clk);
        #2;
        release dut.i_top.wb_peri_adr_i;
        release dut.i_top.wb_peri_dat_i;
        release dut.i_top.wb_peri_we_i;
        release dut.i_top.wb_peri_sel_i;
        release dut.i_top.wb_peri_stb_i;
    endtask

    // Source-side monitor: pops expected beats, checks timing, hold and beat counts
    initial begin : src_mon
        beat_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    stall_seen++;
                    check("hold_while_stalled",
                          {19'd0, dut.src_tvalid, dut.src_tuser, dut.src_tlast, dut.src_tdata},
                          {19'd0, 1'b1, prev_u, prev_l, prev_d});
                end
                if (dut.src_tvalid && dut.src_tready) begin
                    if (src_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL src_extra_beat: got data %0d expected no beat", dut.src_tdata);
                    end else begin
                        e = src_q.pop_front();
                        check("src_tdata", 32'(dut.src_tdata), 32'(e.d));
                        check("src_tuser", 32'(dut.src_tuser), 32'(e.u));
                        check("src_tlast", 32'(dut.src_tlast), 32'(e.l));
                        dst_q.push_back(e);
                        if (arm_first) begin
                            first_cyc = cyc;
                            arm_first = 1'b0;
                        end
                        if (e.u) begin
                            if (timing_en && have_user)
                                check("frame_period", 32'(cyc - last_user_cyc), 32'(FRAME));
                            if (cnt_valid)
                                check("beats_per_frame", 32'(beat_cnt), 32'(XN * YN));
                            have_user = 1'b1;
                            last_user_cyc = cyc;
                            beat_cnt = 0;
                            cnt_valid = 1'b1;
                            user_beats++;
                        end else if (e.s && timing_en && have_sol) begin
                            check("line_period", 32'(cyc - last_sol_cyc), 32'(LINE));
                        end
                        if (e.s) begin
                            have_sol = 1'b1;
                            last_sol_cyc = cyc;
                        end
                        beat_cnt++;
                    end
                end
                prev_stall = dut.src_tvalid && !dut.src_tready;
                prev_d = dut.src_tdata;
                prev_u = dut.src_tuser;
                prev_l = dut.src_tlast;
            end
        end
    end

    // Sink-side monitor: every processed beat must match what entered the top
    initial begin : dst_mon
        beat_t e;
        forever begin
            @(negedge clk);
            if (!reset && dut.dst_tvalid) begin
                if (dut.dst_tuser) $display("frame %d", dut.out_frame_cnt);
                if (dst_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dst_extra_beat: got data %0d expected no beat", dut.dst_tdata);
                end else begin
                    e = dst_q.pop_front();
                    check("dst_tdata", 32'(dut.dst_tdata), 32'(e.d));
                    check("dst_tuser", 32'(dut.dst_tuser), 32'(e.u));
                    check("dst_tlast", 32'(dut.dst_tlast), 32'(e.l));
                end
            end
        end
    end

    initial begin : main
        int rel;
        int n;
        int target;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_tvalid", 32'(dut.src_tvalid), 32'd0);
        check("rst_tdata", 32'(dut.src_tdata), 32'd0);
        check("rst_tuser", 32'(dut.src_tuser), 32'd0);
        check("rst_tlast", 32'(dut.src_tlast), 32'd0);
        check("rst_x", dut.x, 32'd0);
        check("rst_y", dut.y, 32'd0);
        check("rst_frame_cnt", 32'(dut.frame_cnt), 32'd0);
        check("rst_out_frame", dut.out_frame_cnt, 32'd0);
        check("rst_out_line", dut.out_line_cnt, 32'd0);
        check("rst_out_pix", dut.out_pix_cnt, 32'd0);

        // Release reset, unthrottled: timing and pattern of frames 0..2
        push_frames(0, 6);
        first_cyc = -1;
        arm_first = 1'b1;
        timing_en = 1'b1;
        reset = 1'b0;
        rel = cyc;
        n = 0;
        while (arm_first && n < 20) begin @(posedge clk); #2; n++; end
        check("first_beat_cycle", 32'(first_cyc), 32'(rel + 2));
        n = 0;
        while (user_beats < 3 && n < 300) begin @(posedge clk); #2; n++; end
        check("reach_frame2", 32'(user_beats >= 3), 32'd1);

        // Throttle the camera input: every other cycle stalled
        timing_en = 1'b0;
        wb_write(64'd1);
        n = 0;
        while (user_beats < 5 && n < 600) begin @(posedge clk); #2; n++; end
        check("reach_frame4", 32'(user_beats >= 5), 32'd1);

        // Reset in the middle of a line at x == 3
        n = 0;
        while (!(dut.x == 32'd3 && dut.src_tvalid) && n < 200) begin @(posedge clk); #2; n++; end
        check("found_x3", 32'(dut.x), 32'd3);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("midrst_tvalid", 32'(dut.src_tvalid), 32'd0);
        check("midrst_tlast", 32'(dut.src_tlast), 32'd0);
        check("midrst_x", dut.x, 32'd0);
        check("midrst_frame_cnt", 32'(dut.frame_cnt), 32'd0);
        check("midrst_out_frame", dut.out_frame_cnt, 32'd0);
        src_q.delete();
        dst_q.delete();
        push_frames(0, 3);
        have_sol = 1'b0;
        have_user = 1'b0;
        cnt_valid = 1'b0;
        first_cyc = -1;
        arm_first = 1'b1;
        timing_en = 1'b1;
        target = user_beats + 2;
        @(posedge clk);
        #2;
        reset = 1'b0;
        rel = cyc;
        n = 0;
        while (arm_first && n < 20) begin @(posedge clk); #2; n++; end
        check("restart_beat_cycle", 32'(first_cyc), 32'(rel + 2));
        check("restart_frame_cnt", 32'(dut.frame_cnt), 32'd0);

        // One full frame looped through the top
        n = 0;
        while (user_beats < target && n < 200) begin @(posedge clk); #2; n++; end
        check("reach_next_frame", 32'(user_beats >= target), 32'd1);
        check("out_frame_cnt", dut.out_frame_cnt, 32'd1);
        check("out_line_cnt", dut.out_line_cnt, 32'(YN));
        check("out_pix_cnt", dut.out_pix_cnt, 32'(XN * YN));
        repeat (4) @(posedge clk);
        #2;
        check("stalls_observed", 32'(stall_seen > 0), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
